// File: rtl/rc4_pkg.sv
// Shared types for the RC4 phase controller: FSM states, RAM-owner phases, engine count.
package rc4_pkg;

    localparam int unsigned NUM_ENG = 3;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_INIT_KICK = 4'd1,
        ST_INIT_RUN  = 4'd2,
        ST_KSA_KICK  = 4'd3,
        ST_KSA_RUN   = 4'd4,
        ST_PRGA_KICK = 4'd5,
        ST_PRGA_RUN  = 4'd6,
        ST_DONE      = 4'd7,
        ST_ERROR     = 4'd8
    } ctrl_state_t;

    typedef enum logic [1:0] {
        PH_NONE = 2'd0,
        PH_INIT = 2'd1,
        PH_KSA  = 2'd2,
        PH_PRGA = 2'd3
    } phase_t;

    // RAM owner for a given state; KICK and RUN of an engine share its phase
    function automatic phase_t state_phase(input ctrl_state_t s);
        case (s)
            ST_INIT_KICK, ST_INIT_RUN: return PH_INIT;
            ST_KSA_KICK,  ST_KSA_RUN:  return PH_KSA;
            ST_PRGA_KICK, ST_PRGA_RUN: return PH_PRGA;
            default:                   return PH_NONE;
        endcase
    endfunction

    function automatic ctrl_state_t run_next(input ctrl_state_t s);
        case (s)
            ST_INIT_RUN: return ST_KSA_KICK;
            ST_KSA_RUN:  return ST_PRGA_KICK;
            default:     return ST_DONE;
        endcase
    endfunction

endpackage

// File: rtl/s_mem_port_mux.sv
// Zero-latency S RAM port mux: the engine selected by the phase owns the port.
module s_mem_port_mux
    import rc4_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  phase_t                      i_phase,
    input  logic                        i_abort,
    input  logic [NUM_ENG*ADDR_W-1:0]   i_eng_addr,
    input  logic [NUM_ENG*DATA_W-1:0]   i_eng_data,
    input  logic [NUM_ENG-1:0]          i_eng_wren,
    output logic [ADDR_W-1:0]           o_mem_addr,
    output logic [DATA_W-1:0]           o_mem_data,
    output logic                        o_mem_wren
);

    logic w_wren;

    always_comb begin
        o_mem_addr = '0;
        o_mem_data = '0;
        w_wren     = 1'b0;
        case (i_phase)
            PH_INIT: begin
                o_mem_addr = i_eng_addr[0*ADDR_W +: ADDR_W];
                o_mem_data = i_eng_data[0*DATA_W +: DATA_W];
                w_wren     = i_eng_wren[0];
            end
            PH_KSA: begin
                o_mem_addr = i_eng_addr[1*ADDR_W +: ADDR_W];
                o_mem_data = i_eng_data[1*DATA_W +: DATA_W];
                w_wren     = i_eng_wren[1];
            end
            PH_PRGA: begin
                o_mem_addr = i_eng_addr[2*ADDR_W +: ADDR_W];
                o_mem_data = i_eng_data[2*DATA_W +: DATA_W];
                w_wren     = i_eng_wren[2];
            end
            default: ;
        endcase
        // abort blocks any write in the cycle it is seen
        o_mem_wren = w_wren & ~i_abort;
    end

endmodule

// File: rtl/rc4_phase_controller.sv
// Sequences the INIT/KSA/PRGA engines through start/finish handshakes and
// hands the single-port S RAM to the engine of the current phase.
module rc4_phase_controller
    import rc4_pkg::*;
#(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned ACK_TIMEOUT = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        go,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [1:0]                  phase,
    output logic [NUM_ENG-1:0]          eng_start,
    input  logic [NUM_ENG-1:0]          eng_finish,
    input  logic [NUM_ENG*ADDR_W-1:0]   eng_addr,
    input  logic [NUM_ENG*DATA_W-1:0]   eng_data,
    input  logic [NUM_ENG-1:0]          eng_wren,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_data,
    output logic                        mem_wren
);

    // RUN cycles allowed before the drop is overdue; the KICK cycle is the first of ACK_TIMEOUT
    localparam logic [CNT_W-1:0] ACK_LIM = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    ctrl_state_t          r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_dropped;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;
    phase_t               r_phase;
    logic [NUM_ENG-1:0]   r_start;

    ctrl_state_t          w_state_nxt;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_dropped_nxt;
    logic                 w_fin;
    logic                 w_dropped_now;
    logic                 w_complete;
    logic                 w_timeout;

    always_comb begin
        w_fin = 1'b1;
        case (r_phase)
            PH_INIT: w_fin = eng_finish[0];
            PH_KSA:  w_fin = eng_finish[1];
            PH_PRGA: w_fin = eng_finish[2];
            default: ;
        endcase
    end

    // A finish seen high before any drop is never completion
    assign w_dropped_now = r_dropped | ~w_fin;
    assign w_complete    = r_dropped & w_fin;
    assign w_timeout     = ~w_dropped_now & (r_cnt >= ACK_LIM);

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = '0;
        w_dropped_nxt = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (go) w_state_nxt = ST_INIT_KICK;
            end
            ST_INIT_KICK: begin
                w_state_nxt = ST_INIT_RUN;
                w_cnt_nxt   = CNT_W'(1);
            end
            ST_KSA_KICK: begin
                w_state_nxt = ST_KSA_RUN;
                w_cnt_nxt   = CNT_W'(1);
            end
            ST_PRGA_KICK: begin
                w_state_nxt = ST_PRGA_RUN;
                w_cnt_nxt   = CNT_W'(1);
            end
            ST_INIT_RUN, ST_KSA_RUN, ST_PRGA_RUN: begin
                if (w_complete)     w_state_nxt = run_next(r_state);
                else if (w_timeout) w_state_nxt = ST_ERROR;
                w_dropped_nxt = w_dropped_now;
                w_cnt_nxt     = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
            end
            ST_ERROR: ;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (abort) begin
            w_state_nxt   = ST_IDLE;
            w_cnt_nxt     = '0;
            w_dropped_nxt = 1'b0;
        end
    end

    // Status outputs are registered from the next state so they align with it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_dropped <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
            r_phase   <= PH_NONE;
            r_start   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_dropped <= w_dropped_nxt;
            r_busy    <= (state_phase(w_state_nxt) != PH_NONE);
            r_done    <= (w_state_nxt == ST_DONE);
            r_error   <= (w_state_nxt == ST_ERROR);
            r_phase   <= state_phase(w_state_nxt);
            r_start   <= {w_state_nxt == ST_PRGA_KICK,
                          w_state_nxt == ST_KSA_KICK,
                          w_state_nxt == ST_INIT_KICK};
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign phase     = r_phase;
    assign eng_start = r_start;

    s_mem_port_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .i_phase    (r_phase),
        .i_abort    (abort),
        .i_eng_addr (eng_addr),
        .i_eng_data (eng_data),
        .i_eng_wren (eng_wren),
        .o_mem_addr (mem_addr),
        .o_mem_data (mem_data),
        .o_mem_wren (mem_wren)
    );

endmodule

// File: tb/tb_rc4_phase_controller.sv
// Directed bench for rc4_phase_controller with behavioural INIT/KSA/PRGA engine models.
module tb_rc4_phase_controller;

    logic        clk     = 1'b0;
    logic        reset_n = 1'b1;
    logic        go      = 1'b0;
    logic        abort   = 1'b0;
    logic        busy, done, error;
    logic [1:0]  phase;
    logic [2:0]  eng_start;
    logic [2:0]  eng_finish;
    logic [23:0] eng_addr;
    logic [23:0] eng_data;
    logic [2:0]  eng_wren = 3'b111;
    logic [7:0]  mem_addr, mem_data;
    logic        mem_wren;

    int n_vec = 0;
    int n_err = 0;
    int n;

    // Engine i holds finish low for len[i] cycles, starting dly[i]+1 cycles after seeing start
    int c[3];
    int dly[3] = '{0, 0, 0};
    int len[3] = '{256, 768, 96};

    assign eng_addr = 24'h332211;
    assign eng_data = 24'hA3A2A1;

    rc4_phase_controller #(.ADDR_W(8), .DATA_W(8), .ACK_TIMEOUT(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .go         (go),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .phase      (phase),
        .eng_start  (eng_start),
        .eng_finish (eng_finish),
        .eng_addr   (eng_addr),
        .eng_data   (eng_data),
        .eng_wren   (eng_wren),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .mem_wren   (mem_wren)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) c[i] <= 0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (eng_start[i])                 c[i] <= 1;
                else if (c[i] != 0 && c[i] < 100000) c[i] <= c[i] + 1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++)
            eng_finish[i] = (c[i] == 0) || !(c[i] > dly[i] && c[i] <= dly[i] + len[i]);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Ticks until a start pulse (or done) shows up, bounded by max
    task automatic wait_for(input bit want_done, input int max, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (cnt < max && (want_done ? (done !== 1'b1) : (eng_start === 3'b000)));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        // Reset values
        #2 reset_n = 1'b0;
        #3;
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_error", 32'(error),     32'd0);
        chk("rst_phase", 32'(phase),     32'd0);
        chk("rst_start", 32'(eng_start), 32'd0);
        chk("rst_addr",  32'(mem_addr),  32'd0);
        chk("rst_data",  32'(mem_data),  32'd0);
        chk("rst_wren",  32'(mem_wren),  32'd0);
        @(negedge clk) reset_n = 1'b1;
        tick();
        tick();
        chk("idle_addr", 32'(mem_addr), 32'd0);
        chk("idle_wren", 32'(mem_wren), 32'd0);

        // 1. Nominal run with owner/non-owner write isolation
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("n_start_init", 32'(eng_start), 32'b001);
        chk("n_busy",       32'(busy),      32'd1);
        chk("n_phase_init", 32'(phase),     32'd1);
        chk("n_addr_init",  32'(mem_addr),  32'h11);
        eng_wren = 3'b110; #1;
        chk("n_wren_init_nonowner", 32'(mem_wren), 32'd0);
        eng_wren = 3'b001; #1;
        chk("n_wren_init_owner", 32'(mem_wren), 32'd1);
        chk("n_data_init",       32'(mem_data), 32'hA1);
        wait_for(1'b0, 400, n);
        chk("n_init_cycles", 32'(n),         32'd258);
        chk("n_start_ksa",   32'(eng_start), 32'b010);
        chk("n_phase_ksa",   32'(phase),     32'd2);
        chk("n_addr_ksa",    32'(mem_addr),  32'h22);
        eng_wren = 3'b101; #1;
        chk("n_wren_ksa_nonowner", 32'(mem_wren), 32'd0);
        eng_wren = 3'b010; #1;
        chk("n_wren_ksa_owner", 32'(mem_wren), 32'd1);
        tick();
        chk("n_ksa_pulse_1cyc", 32'(eng_start), 32'b000);
        wait_for(1'b0, 1000, n);
        chk("n_ksa_cycles",   32'(n),         32'd769);
        chk("n_start_prga",   32'(eng_start), 32'b100);
        chk("n_addr_prga",    32'(mem_addr),  32'h33);
        eng_wren = 3'b011; #1;
        chk("n_wren_prga_nonowner", 32'(mem_wren), 32'd0);
        eng_wren = 3'b100; #1;
        chk("n_wren_prga_owner", 32'(mem_wren), 32'd1);
        tick();
        chk("n_prga_pulse_1cyc", 32'(eng_start), 32'b000);
        wait_for(1'b1, 200, n);
        chk("n_prga_cycles", 32'(n),        32'd97);
        chk("n_done",        32'(done),     32'd1);
        chk("n_done_busy",   32'(busy),     32'd0);
        chk("n_done_phase",  32'(phase),    32'd0);
        eng_wren = 3'b111; #1;
        chk("n_done_addr",   32'(mem_addr), 32'd0);
        chk("n_done_wren",   32'(mem_wren), 32'd0);

        // 2. KSA never acknowledges
        len[1] = 0;
        go = 1'b1;
        tick();
        go = 1'b0;
        wait_for(1'b0, 400, n);
        chk("t_start_ksa", 32'(eng_start), 32'b010);
        repeat (3) tick();
        chk("t_err_early", 32'(error), 32'd0);
        chk("t_busy_early", 32'(busy), 32'd1);
        tick();
        chk("t_err",       32'(error), 32'd1);
        chk("t_err_busy",  32'(busy),  32'd0);
        chk("t_err_phase", 32'(phase), 32'd0);
        go = 1'b1;
        tick();
        tick();
        chk("t_err_held",     32'(error),     32'd1);
        chk("t_err_no_start", 32'(eng_start), 32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        go = 1'b0;
        chk("t_abort_err",  32'(error), 32'd0);
        chk("t_abort_busy", 32'(busy),  32'd0);
        chk("t_abort_done", 32'(done),  32'd0);
        len[1] = 768;

        // 3. Abort while INIT writes
        go = 1'b1;
        tick();
        go = 1'b0;
        repeat (8'h40) tick();
        eng_wren = 3'b001; #1;
        chk("a_wren_before", 32'(mem_wren), 32'd1);
        abort = 1'b1; #1;
        chk("a_wren_gated", 32'(mem_wren), 32'd0);
        chk("a_addr_owner", 32'(mem_addr), 32'h11);
        tick();
        abort = 1'b0;
        chk("a_phase", 32'(phase),     32'd0);
        chk("a_busy",  32'(busy),      32'd0);
        chk("a_start", 32'(eng_start), 32'd0);

        // 4. Asynchronous reset mid-PRGA
        eng_wren = 3'b111;
        go = 1'b1;
        tick();
        go = 1'b0;
        wait_for(1'b0, 400, n);
        tick();
        wait_for(1'b0, 1000, n);
        chk("r_in_prga", 32'(phase), 32'd3);
        repeat (10) tick();
        #2 reset_n = 1'b0;
        #1;
        chk("r_busy",  32'(busy),      32'd0);
        chk("r_phase", 32'(phase),     32'd0);
        chk("r_start", 32'(eng_start), 32'd0);
        chk("r_addr",  32'(mem_addr),  32'd0);
        chk("r_wren",  32'(mem_wren),  32'd0);
        #3 reset_n = 1'b1;
        tick();
        chk("r_idle_busy", 32'(busy), 32'd0);
        chk("r_idle_done", 32'(done), 32'd0);

        // 5. go held through DONE, then finish rising on the expiry cycle
        go = 1'b1;
        tick();
        wait_for(1'b0, 400, n);
        tick();
        wait_for(1'b0, 1000, n);
        tick();
        wait_for(1'b1, 200, n);
        chk("e_done", 32'(done), 32'd1);
        tick();
        go = 1'b0;
        chk("e_restart_done",  32'(done),      32'd0);
        chk("e_restart_start", 32'(eng_start), 32'b001);
        dly[0] = 1;
        len[0] = 1;
        repeat (3) tick();
        chk("e_still_run", 32'(phase), 32'd1);
        tick();
        chk("e_expiry_adv",   32'(eng_start), 32'b010);
        chk("e_expiry_noerr", 32'(error),     32'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("e_idle_phase", 32'(phase),    32'd0);
        chk("e_idle_addr",  32'(mem_addr), 32'd0);
        dly[0] = 0;
        len[0] = 256;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
